// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Optional FETCH_Q_PERF_EN adds a hold-cycle counter on the top module.
package fetch_queue_pkg;

    localparam int          WORD_W      = 16;
    localparam int          FQ_DEPTH    = 4;
    localparam logic [15:0] FQ_RESET_PC = 16'h0000;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_REDIRECT = 1'b1
    } fq_state_e;

    // Pointer width for a power-of-two depth; a depth of 2 still needs one bit.
    function automatic int fq_log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and fetch-side handshake bundle of the prefetch queue.
// The slave modport is the queue; the master modport is memory plus fetch unit.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic  mem_req;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_data;
    word_t fetch_opc;
    word_t fetch_arg;
    logic  hold;
    logic  adv;
    logic  adv2;
    logic  redirect;
    word_t redirect_pc;

    modport slave (
        output mem_req, mem_addr, fetch_opc, fetch_arg, hold,
        input  mem_ack, mem_data, adv, adv2, redirect, redirect_pc
    );

    modport master (
        input  mem_req, mem_addr, fetch_opc, fetch_arg, hold,
        output mem_ack, mem_data, adv, adv2, redirect, redirect_pc
    );

endinterface

// File: rtl/fq_ram.sv
// DEPTH x 16 register-array storage for the prefetch queue:
// one write port and two asynchronous read ports.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = fq_log2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    output word_t         o_rdata0,
    output word_t         o_rdata1
);

    word_t r_mem [DEPTH];

    // NOTE: the array is reset on purpose so the head pair reads zero out of
    // reset; this keeps it a flop array rather than something an SRAM could absorb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: streams words from memory, presents the head pair.
// Define FETCH_Q_PERF_EN to add the saturating perf_hold_cnt output.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int    DEPTH    = FQ_DEPTH,
    parameter word_t RESET_PC = FQ_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave bus
`ifdef FETCH_Q_PERF_EN
    ,
    output logic [15:0]  perf_hold_cnt
`endif
);

    localparam int AW = fq_log2(DEPTH);
    localparam int CW = AW + 1;

    fq_state_e     r_state;
    fq_state_e     w_state_next;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    word_t         r_addr;
    logic          r_started;

    logic          w_req;
    logic          w_hold;
    logic          w_push;
    logic [CW-1:0] w_pop_n;
    logic [AW-1:0] w_rd_next;
    word_t         w_rdata0;
    word_t         w_rdata1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_hold       = 1'b1;
        w_push       = 1'b0;
        w_pop_n      = '0;

        case (r_state)
            S_RUN: begin
                w_req  = r_started && (r_count < CW'(DEPTH));
                w_hold = (r_count < CW'(2));
            end
            S_REDIRECT: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase

        // Redirect wins over everything: it flushes and drops any same-cycle ack.
        if (bus.redirect) begin
            w_state_next = S_REDIRECT;
        end else begin
            w_push = w_req && bus.mem_ack;
            if (bus.adv && !w_hold) w_pop_n = bus.adv2 ? CW'(2) : CW'(1);
        end
    end

    assign w_rd_next = r_rd + AW'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started <= 1'b0;
            r_count   <= '0;
            r_rd      <= '0;
            r_wr      <= '0;
            r_addr    <= RESET_PC;
        end else begin
            r_started <= 1'b1;
            if (bus.redirect) begin
                r_count <= '0;
                r_rd    <= '0;
                r_wr    <= '0;
                r_addr  <= bus.redirect_pc;
            end else begin
                if (w_push) begin
                    r_wr   <= r_wr + AW'(1);
                    r_addr <= r_addr + 16'd1;
                end
                r_rd    <= r_rd + AW'(w_pop_n);
                r_count <= r_count + CW'(w_push) - w_pop_n;
            end
        end
    end

    fq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_push),
        .i_waddr  (r_wr),
        .i_wdata  (bus.mem_data),
        .i_raddr0 (r_rd),
        .i_raddr1 (w_rd_next),
        .o_rdata0 (w_rdata0),
        .o_rdata1 (w_rdata1)
    );

    assign bus.mem_req   = w_req;
    assign bus.mem_addr  = r_addr;
    assign bus.fetch_opc = w_rdata0;
    assign bus.fetch_arg = w_rdata1;
    assign bus.hold      = w_hold;

`ifdef FETCH_Q_PERF_EN
    logic [15:0] r_perf_hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_perf_hold_cnt <= '0;
        else if (w_hold && (r_perf_hold_cnt != 16'hFFFF)) r_perf_hold_cnt <= r_perf_hold_cnt + 16'd1;
    end

    assign perf_hold_cnt = r_perf_hold_cnt;
`endif

    // A pop request while the pair is not valid is dropped; flag it in simulation.
    adv_while_hold: assert property (@(posedge clk) disable iff (rst) !(bus.adv && bus.hold))
        else $warning("fetch_queue: adv ignored while hold=1");

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: scoreboard of expected word stream checked by a
// negedge monitor on each consumed pair, plus direct checks of address/handshake.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;

    fetch_queue_if bus ();

`ifdef FETCH_Q_PERF_EN
    logic [15:0] perf_hold_cnt;
`endif

    fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_Q_PERF_EN
        ,
        .perf_hold_cnt (perf_hold_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    word_t exp_q [$];

    function automatic word_t mem_word(input word_t a);
        return {a[7:0], a[15:8]} ^ 16'hC3C3;
    endfunction

    // Memory model: data always corresponds to the presented address.
    always_comb bus.mem_data = mem_word(bus.mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_exp(input word_t start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + word_t'(i));
        for (int i = 0; i < n; i++) exp_q[i] = mem_word(exp_q[i]);
    endtask

    // Monitor: every accepted pop must present the next words of the expected stream.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.hold === 1'b0 && bus.adv === 1'b1 && bus.redirect === 1'b0) begin
            if (exp_q.size() < 2) begin
                check("sb_depth", exp_q.size(), 2);
            end else begin
                check("sb_opc", bus.fetch_opc, exp_q[0]);
                check("sb_arg", bus.fetch_arg, exp_q[1]);
                void'(exp_q.pop_front());
                if (bus.adv2) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.adv         = 1'b0;
        bus.adv2        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        #2;
        check("rst_hold", bus.hold, 1);
        check("rst_req", bus.mem_req, 0);
        check("rst_addr", bus.mem_addr, 16'h0000);
        check("rst_opc", bus.fetch_opc, 16'h0000);
        check("rst_arg", bus.fetch_arg, 16'h0000);

        // Fill from reset with a constant ack.
        tick();
        rst = 1'b0;
        fill_exp(16'h0000, 32);
        bus.mem_ack = 1'b1;
        check("req_before_first_clk", bus.mem_req, 0);
        tick();
        check("req_first", bus.mem_req, 1);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", bus.mem_addr, i);
            check("fill_req", bus.mem_req, 1);
            tick();
            check("fill_hold", bus.hold, (i == 0) ? 1 : 0);
        end
        check("full_req", bus.mem_req, 0);
        check("full_addr", bus.mem_addr, 16'h0004);
        check("full_opc", bus.fetch_opc, mem_word(16'h0000));
        check("full_arg", bus.fetch_arg, mem_word(16'h0001));
        tick();
        check("full_addr_stay", bus.mem_addr, 16'h0004);

        // Streaming pops of 1 and 2 words while memory keeps acking.
        for (int c = 0; c < 12; c++) begin
            bus.adv  = ~bus.hold;
            bus.adv2 = (c % 3) != 2;
            tick();
        end
        bus.adv  = 1'b0;
        bus.adv2 = 1'b0;
        repeat (5) tick();

        // Redirect to 0100, collect three words, then redirect with a live ack.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        fill_exp(16'h0100, 8);
        tick();
        bus.redirect = 1'b0;
        check("rd1_hold", bus.hold, 1);
        check("rd1_req", bus.mem_req, 0);
        check("rd1_addr", bus.mem_addr, 16'h0100);
        tick();
        check("rd1_req_run", bus.mem_req, 1);
        repeat (3) tick();
        check("cnt3_addr", bus.mem_addr, 16'h0103);
        check("cnt3_req", bus.mem_req, 1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h1234;
        fill_exp(16'h1234, 8);
        tick();
        bus.redirect = 1'b0;
        check("rd2_hold", bus.hold, 1);
        check("rd2_req", bus.mem_req, 0);
        check("rd2_addr", bus.mem_addr, 16'h1234);
        tick();
        check("rd2_req_run", bus.mem_req, 1);
        check("rd2_hold_run", bus.hold, 1);
        tick();
        check("rd2_hold_one", bus.hold, 1);
        tick();
        check("rd2_hold_two", bus.hold, 0);
        check("rd2_opc", bus.fetch_opc, mem_word(16'h1234));
        check("rd2_arg", bus.fetch_arg, mem_word(16'h1235));
        bus.adv  = 1'b1;
        bus.adv2 = 1'b1;
        tick();
        bus.adv  = 1'b0;
        bus.adv2 = 1'b0;

        // Back-to-back redirect: the second one reloads the address and extends the bubble.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h2000;
        fill_exp(16'h2000, 8);
        tick();
        bus.redirect_pc = 16'h3000;
        fill_exp(16'h3000, 8);
        tick();
        bus.redirect = 1'b0;
        check("rr_addr", bus.mem_addr, 16'h3000);
        check("rr_req", bus.mem_req, 0);
        check("rr_hold", bus.hold, 1);
        tick();
        check("rr_req_run", bus.mem_req, 1);
        check("rr_addr_run", bus.mem_addr, 16'h3000);

        // Address wrap FFFF -> 0000 with word order preserved.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        fill_exp(16'hFFFE, 8);
        tick();
        bus.redirect = 1'b0;
        tick();
        check("wrap_a0", bus.mem_addr, 16'hFFFE);
        tick();
        check("wrap_a1", bus.mem_addr, 16'hFFFF);
        tick();
        check("wrap_a2", bus.mem_addr, 16'h0000);
        tick();
        check("wrap_a3", bus.mem_addr, 16'h0001);
        check("wrap_opc0", bus.fetch_opc, mem_word(16'hFFFE));
        check("wrap_arg0", bus.fetch_arg, mem_word(16'hFFFF));
        bus.adv  = 1'b1;
        bus.adv2 = 1'b1;
        tick();
        bus.adv  = 1'b0;
        bus.adv2 = 1'b0;
        check("wrap_opc1", bus.fetch_opc, mem_word(16'h0000));
        check("wrap_arg1", bus.fetch_arg, mem_word(16'h0001));

        // Pop request with a single word queued must be ignored.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        bus.mem_ack     = 1'b0;
        fill_exp(16'h0040, 8);
        tick();
        bus.redirect = 1'b0;
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("one_hold", bus.hold, 1);
        check("one_addr", bus.mem_addr, 16'h0041);
        bus.adv  = 1'b1;
        bus.adv2 = 1'b1;
        tick();
        bus.adv  = 1'b0;
        bus.adv2 = 1'b0;
        check("ign_hold", bus.hold, 1);
        check("ign_opc", bus.fetch_opc, mem_word(16'h0040));
        check("ign_addr", bus.mem_addr, 16'h0041);
        bus.mem_ack = 1'b1;
        tick();
        check("ign_pair_hold", bus.hold, 0);
        check("ign_pair_opc", bus.fetch_opc, mem_word(16'h0040));
        check("ign_pair_arg", bus.fetch_arg, mem_word(16'h0041));

        // Asynchronous reset mid-stream, then an ack-less stretch.
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_hold", bus.hold, 1);
        check("arst_req", bus.mem_req, 0);
        check("arst_addr", bus.mem_addr, 16'h0000);
        check("arst_opc", bus.fetch_opc, 16'h0000);
        bus.mem_ack = 1'b0;
        fill_exp(16'h0000, 8);
        tick();
        rst = 1'b0;
        repeat (10) tick();
`ifdef FETCH_Q_PERF_EN
        check("perf_hold_cnt", perf_hold_cnt, 16'd10);
`endif
        check("idle_addr", bus.mem_addr, 16'h0000);
        check("idle_req", bus.mem_req, 1);
        check("idle_hold", bus.hold, 1);
        bus.mem_ack = 1'b1;
        repeat (2) tick();
        check("post_hold", bus.hold, 0);
        check("post_opc", bus.fetch_opc, mem_word(16'h0000));
        check("post_arg", bus.fetch_arg, mem_word(16'h0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
